// File: rtl/match_serializer_pkg.sv
// Shared constants and types for the index-match serializer slice.
// Supplies lane/position geometry and the serializer state encoding.
package aim_pkg;

    localparam int LANES  = 32;
    localparam int POS_W  = 9;
    localparam int LANE_W = $clog2(LANES);
    localparam int CNT_W  = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } ms_state_e;

    typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/match_serializer_lsb_prienc.sv
// Combinational lowest-set-bit encoder over a lane mask.
// Also reports whether any bit is set and whether exactly one bit is set.
module lsb_prienc
    import aim_pkg::*;
#(
    parameter int LANES  = 32,
    parameter int LANE_W = $clog2(LANES)
) (
    input  logic [LANES-1:0]  mask,
    output logic [LANE_W-1:0] idx,
    output logic              any,
    output logic              onehot
);

    logic [LANES-1:0] mask_dec;

    always_comb begin
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = LANE_W'(i);
            end
        end
    end

    assign mask_dec = mask - {{(LANES-1){1'b0}}, 1'b1};
    assign any      = |mask;
    // Clearing the lowest set bit leaves nothing only when a single bit was set.
    assign onehot   = any & ((mask & mask_dec) == '0);

endmodule

// File: rtl/match_serializer.sv
// Captures one batch of per-lane index hits and drains them one (lane, pos)
// pair per cycle, lowest lane first, with hit counting and end-of-job pulse.
module match_serializer #(
    parameter int LANES  = 32,
    parameter int POS_W  = 9,
    parameter int LANE_W = $clog2(LANES),
    parameter int CNT_W  = 10
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic                         i_in_last,
    input  logic [LANES-1:0]             i_hit,
    input  logic [LANES-1:0][POS_W-1:0]  i_pos,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [LANE_W-1:0]            o_lane,
    output logic [POS_W-1:0]             o_pos,
    output logic                         o_out_last,
    output logic [CNT_W-1:0]             o_hit_count,
    output logic                         o_done
);

    import aim_pkg::*;

    ms_state_e                   state, state_nxt;
    logic [LANES-1:0]            hit_clean;
    logic [LANES-1:0]            mask_r;
    logic [LANES-1:0][POS_W-1:0] pos_r;
    logic                        last_r;
    logic                        job_end_r;
    logic [CNT_W-1:0]            count_r;
    logic [LANE_W-1:0]           low_idx;
    logic                        mask_any;
    logic                        mask_onehot;
    logic                        accept;
    logic                        handshake;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Only a definite 1 counts as a hit; X/Z lanes are dropped.
    always_comb begin
        hit_clean = '0;
        for (int i = 0; i < LANES; i++) begin
            hit_clean[i] = (i_hit[i] === 1'b1);
        end
    end

    lsb_prienc #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_prienc (
        .mask   (mask_r),
        .idx    (low_idx),
        .any    (mask_any),
        .onehot (mask_onehot)
    );

    assign accept    = i_in_valid & (state == S_IDLE);
    assign handshake = (state == S_DRAIN) & i_out_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else if (i_clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_done      = 1'b0;
        case (state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    if (|hit_clean) begin
                        state_nxt = S_DRAIN;
                    end else if (i_in_last) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                o_out_valid = 1'b1;
                if (i_out_ready && mask_onehot) begin
                    state_nxt = last_r ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // job_end_r remembers that o_done fired so the next job restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask_r    <= '0;
            pos_r     <= '0;
            last_r    <= 1'b0;
            job_end_r <= 1'b0;
            count_r   <= '0;
        end else if (i_clear) begin
            mask_r    <= '0;
            last_r    <= 1'b0;
            job_end_r <= 1'b0;
            count_r   <= '0;
        end else begin
            if (accept) begin
                mask_r    <= hit_clean;
                pos_r     <= i_pos;
                last_r    <= i_in_last;
                job_end_r <= 1'b0;
                if (job_end_r) begin
                    count_r <= '0;
                end
            end
            if (handshake && mask_any) begin
                mask_r  <= mask_r & (mask_r - {{(LANES-1){1'b0}}, 1'b1});
                count_r <= sat_inc(count_r);
            end
            if (state == S_DONE) begin
                job_end_r <= 1'b1;
            end
        end
    end

    assign o_lane      = o_out_valid ? low_idx : '0;
    assign o_pos       = o_out_valid ? pos_r[low_idx] : '0;
    assign o_out_last  = o_out_valid & last_r & mask_onehot;
    assign o_hit_count = count_r;

endmodule

// File: tb/tb_match_serializer.sv
// Directed bench for match_serializer: batch drain order, backpressure,
// empty batches, full batch, sync clear and async reset.
module tb_match_serializer;

    localparam int LANES  = 32;
    localparam int POS_W  = 9;
    localparam int LANE_W = 5;
    localparam int CNT_W  = 10;

    logic                        clk;
    logic                        rst_n;
    logic                        clear;
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic [LANES-1:0]            hit;
    logic [LANES-1:0][POS_W-1:0] pos_v;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANE_W-1:0]           lane;
    logic [POS_W-1:0]            pos;
    logic                        out_last;
    logic [CNT_W-1:0]            hit_count;
    logic                        done;

    int checks;
    int failures;

    match_serializer #(
        .LANES  (LANES),
        .POS_W  (POS_W),
        .LANE_W (LANE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (clear),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_last   (in_last),
        .i_hit       (hit),
        .i_pos       (pos_v),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_lane      (lane),
        .o_pos       (pos),
        .o_out_last  (out_last),
        .o_hit_count (hit_count),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [31:0] exp_count);
        chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".lane"},      32'(lane),      32'd0);
        chk({tag, ".pos"},       32'(pos),       32'd0);
        chk({tag, ".out_last"},  32'(out_last),  32'd0);
        chk({tag, ".count"},     32'(hit_count), exp_count);
        chk({tag, ".done"},      32'(done),      32'd0);
    endtask

    task automatic chk_pair(input string tag, input int exp_lane, input int exp_pos, input logic exp_last);
        chk({tag, ".valid"},    32'(out_valid), 32'd1);
        chk({tag, ".in_ready"}, 32'(in_ready),  32'd0);
        chk({tag, ".lane"},     32'(lane),      32'(exp_lane));
        chk({tag, ".pos"},      32'(pos),       32'(exp_pos));
        chk({tag, ".last"},     32'(out_last),  32'(exp_last));
    endtask

    task automatic send_batch(input logic [LANES-1:0] h, input logic last);
        in_valid = 1'b1;
        hit      = h;
        in_last  = last;
        step();
        in_valid = 1'b0;
        hit      = '0;
        in_last  = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        hit       = '0;
        pos_v     = '0;
        out_ready = 1'b0;

        // Reset state
        step();
        step();
        chk_idle_outputs("rst", 32'd0);
        rst_n = 1'b1;
        step();

        // 1: two hits, last batch
        pos_v[0]  = 9'd3;
        pos_v[2]  = 9'd40;
        out_ready = 1'b1;
        send_batch(32'h0000_0005, 1'b1);
        chk_pair("t1.p0", 0, 3, 1'b0);
        step();
        chk_pair("t1.p1", 2, 40, 1'b1);
        step();
        chk("t1.done", 32'(done), 32'd1);
        chk("t1.count", 32'(hit_count), 32'd2);
        chk("t1.valid_off", 32'(out_valid), 32'd0);
        step();
        chk_idle_outputs("t1.idle", 32'd2);

        // 2: backpressure, lanes 0 and 31
        pos_v     = '0;
        pos_v[0]  = 9'd7;
        pos_v[31] = 9'd300;
        out_ready = 1'b0;
        send_batch(32'h8000_0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_pair($sformatf("t2.hold%0d", i), 0, 7, 1'b0);
            step();
        end
        out_ready = 1'b1;
        chk_pair("t2.p0", 0, 7, 1'b0);
        chk("t2.count0", 32'(hit_count), 32'd0);
        step();
        chk_pair("t2.p31", 31, 300, 1'b0);
        step();
        chk_idle_outputs("t2.idle", 32'd2);

        // 3: empty batches
        send_batch('0, 1'b0);
        chk_idle_outputs("t3.empty", 32'd2);
        send_batch('0, 1'b1);
        chk("t3.done", 32'(done), 32'd1);
        chk("t3.count", 32'(hit_count), 32'd2);
        chk("t3.valid", 32'(out_valid), 32'd0);
        chk("t3.last", 32'(out_last), 32'd0);
        step();
        chk_idle_outputs("t3.idle", 32'd2);

        // 4: all lanes hit
        for (int i = 0; i < LANES; i++) pos_v[i] = POS_W'(i + 96);
        send_batch('1, 1'b1);
        for (int i = 0; i < LANES; i++) begin
            chk_pair($sformatf("t4.l%0d", i), i, i + 96, i == LANES - 1);
            step();
        end
        chk("t4.done", 32'(done), 32'd1);
        chk("t4.count", 32'(hit_count), 32'd32);
        step();
        chk_idle_outputs("t4.idle", 32'd32);

        // 5: sync clear after two of five hits
        for (int i = 0; i < LANES; i++) pos_v[i] = POS_W'(i + 10);
        send_batch(32'h0000_001F, 1'b1);
        chk("t5.count_start", 32'(hit_count), 32'd0);
        chk_pair("t5.p0", 0, 10, 1'b0);
        step();
        chk_pair("t5.p1", 1, 11, 1'b0);
        step();
        chk_pair("t5.p2", 2, 12, 1'b0);
        chk("t5.count2", 32'(hit_count), 32'd2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_idle_outputs("t5.clr", 32'd0);
        step();
        chk_idle_outputs("t5.nodone", 32'd0);
        pos_v[4] = 9'd99;
        send_batch(32'h0000_0010, 1'b1);
        chk_pair("t5.new", 4, 99, 1'b1);
        step();
        chk("t5.done", 32'(done), 32'd1);
        chk("t5.count", 32'(hit_count), 32'd1);
        step();

        // 6: async reset mid-drain, X on hit while reset held
        pos_v[1]  = 9'd5;
        pos_v[2]  = 9'd6;
        out_ready = 1'b0;
        send_batch(32'h0000_0006, 1'b1);
        chk_pair("t6.pre", 1, 5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6.async", 32'd0);
        in_valid = 1'b1;
        hit      = 'x;
        step();
        chk_idle_outputs("t6.held", 32'd0);
        in_valid = 1'b0;
        hit      = '0;
        rst_n    = 1'b1;
        step();
        chk_idle_outputs("t6.after", 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
